// File: rtl/echo_detector_if.sv
// echo_detector_if
//   Groups the sample stream and result signals of echo_detector.
//   slave  : the detector side (samples in, results out).
//   master : the producer/consumer side (samples out, results in).
//   Signals:
//     burst_start_in   new-ping pulse
//     sample_in        signed aggregated waveform sample
//     sample_valid_in  qualifier for sample_in / time_in
//     time_in          cycles since emission, travels with the sample
//     threshold_in     unsigned detection threshold (quasi-static)
//     echo_detected_out, echo_valid_out, echo_time_out, no_echo_out  detection results
//     peak_out, peak_time_out, peak_valid_out                          peak tracking results
interface echo_detector_if #(
    parameter int DATA_WIDTH = 16,
    parameter int TIME_WIDTH = 24
);
    logic                         burst_start_in;
    logic signed [DATA_WIDTH-1:0] sample_in;
    logic                         sample_valid_in;
    logic [TIME_WIDTH-1:0]        time_in;
    logic [DATA_WIDTH-1:0]        threshold_in;

    logic                         echo_detected_out;
    logic                         echo_valid_out;
    logic [TIME_WIDTH-1:0]        echo_time_out;
    logic                         no_echo_out;

    logic [DATA_WIDTH-1:0]        peak_out;
    logic [TIME_WIDTH-1:0]        peak_time_out;
    logic                         peak_valid_out;

    modport slave (
        input  burst_start_in, sample_in, sample_valid_in, time_in, threshold_in,
        output echo_detected_out, echo_valid_out, echo_time_out, no_echo_out,
               peak_out, peak_time_out, peak_valid_out
    );

    modport master (
        output burst_start_in, sample_in, sample_valid_in, time_in, threshold_in,
        input  echo_detected_out, echo_valid_out, echo_time_out, no_echo_out,
               peak_out, peak_time_out, peak_valid_out
    );
endinterface

// File: rtl/echo_detector.sv
// echo_detector
//   Per-ping echo decision for the receive chain. Samples are rectified in a
//   registered first stage; a second-stage FSM applies transmit blanking,
//   a confirmation run with hysteresis, and an end-of-window timeout.
//   Results are registered: a one-cycle echo_valid_out pulse two cycles after
//   the confirming sample, a held echo_detected_out level, the time of the
//   first sample of the confirmed run, and a one-cycle no_echo_out pulse when
//   the time window ends without an echo.
//
//   Ports:
//     clk_in  system clock
//     rst_in  asynchronous active-high reset
//     bus     echo_detector_if.slave (sample stream in, results out)
//
//   Build option:
//     ECHO_PEAK_TRACK_EN  enables peak magnitude tracking on peak_out /
//                         peak_time_out / peak_valid_out; when undefined those
//                         outputs are tied to 0.
module echo_detector #(
    parameter int DATA_WIDTH    = 16,
    parameter int TIME_WIDTH    = 24,
    parameter int BLANK_CYCLES  = 1048576,
    parameter int CONFIRM_COUNT = 4,
    parameter int HYST          = 512
) (
    input  logic           clk_in,
    input  logic           rst_in,
    echo_detector_if.slave bus
);

    localparam int CW = $clog2(CONFIRM_COUNT + 1);

    localparam logic [DATA_WIDTH-1:0] MAG_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] NEG_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] HYST_V   = DATA_WIDTH'(HYST);
    localparam logic [TIME_WIDTH-1:0] TIME_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        BLANK,
        ARMED,
        CONFIRM,
        DETECTED,
        DONE
    } state_t;

    // ------------------------------------------------------------------
    // Stage 1: rectify. The most negative code has no positive twin, so it
    // saturates to the largest positive magnitude.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] raw;
    logic [DATA_WIDTH-1:0] mag_d;
    logic [DATA_WIDTH-1:0] mag_q;
    logic [TIME_WIDTH-1:0] time_q;
    logic                  vld_q;

    assign raw = bus.sample_in;

    always_comb begin
        mag_d = raw;
        if (raw == NEG_MIN)
            mag_d = MAG_MAX;
        else if (raw[DATA_WIDTH-1])
            mag_d = '0 - raw;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            vld_q  <= 1'b0;
            mag_q  <= '0;
            time_q <= '0;
        end else if (bus.burst_start_in) begin
            // a sample arriving with the burst belongs to no ping
            vld_q <= 1'b0;
        end else begin
            vld_q <= bus.sample_valid_in;
            if (bus.sample_valid_in) begin
                mag_q  <= mag_d;
                time_q <= bus.time_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: decision FSM on the stage-1 registers
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] low_thr;
    logic                  above;
    logic                  hold_ok;
    logic                  past_blank;
    logic                  last_time;

    // release level sits HYST below threshold, floored at zero
    assign low_thr    = (bus.threshold_in >= HYST_V) ? bus.threshold_in - HYST_V : '0;
    assign above      = mag_q > bus.threshold_in;
    assign hold_ok    = mag_q >= low_thr;
    assign past_blank = 64'(time_q) >= 64'(BLANK_CYCLES);
    assign last_time  = time_q == TIME_MAX;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [TIME_WIDTH-1:0] etime_q, etime_d;
    logic                  det_q, det_d;
    logic                  evalid_q, evalid_d;
    logic                  noecho_q, noecho_d;
    logic                  detect;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            etime_q  <= '0;
            det_q    <= 1'b0;
            evalid_q <= 1'b0;
            noecho_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            etime_q  <= etime_d;
            det_q    <= det_d;
            evalid_q <= evalid_d;
            noecho_q <= noecho_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        etime_d  = etime_q;
        det_d    = det_q;
        evalid_d = 1'b0;
        noecho_d = 1'b0;
        detect   = 1'b0;

        case (state_q)
            // BLANK hands the first post-blank sample straight to the ARMED
            // evaluation in the same cycle, so no sample is lost at the edge.
            BLANK, ARMED: begin
                if (vld_q && (state_q == ARMED || past_blank)) begin
                    state_d = ARMED;
                    if (above) begin
                        etime_d = time_q;
                        cnt_d   = CW'(1);
                        if (CONFIRM_COUNT == 1)
                            detect = 1'b1;
                        else
                            state_d = CONFIRM;
                    end
                end
            end
            CONFIRM: begin
                if (vld_q) begin
                    if (above) begin
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q + CW'(1) == CW'(CONFIRM_COUNT))
                            detect = 1'b1;
                    end else if (!hold_ok) begin
                        // run broken; echo_time_out keeps the stale start time
                        cnt_d   = '0;
                        state_d = ARMED;
                    end
                end
            end
            default: ;
        endcase

        if (detect) begin
            state_d  = DETECTED;
            det_d    = 1'b1;
            evalid_d = 1'b1;
        end else if (vld_q && last_time &&
                     (state_q == BLANK || state_q == ARMED || state_q == CONFIRM)) begin
            noecho_d = 1'b1;
            state_d  = DONE;
        end

        // a new ping overrides everything, from any state
        if (bus.burst_start_in) begin
            state_d  = BLANK;
            cnt_d    = '0;
            etime_d  = '0;
            det_d    = 1'b0;
            evalid_d = 1'b0;
            noecho_d = 1'b0;
        end
    end

    assign bus.echo_detected_out = det_q;
    assign bus.echo_valid_out    = evalid_q;
    assign bus.echo_time_out     = etime_q;
    assign bus.no_echo_out       = noecho_q;

`ifdef ECHO_PEAK_TRACK_EN
    // ------------------------------------------------------------------
    // Peak tracking: max magnitude from the start of a run until a fixed
    // window of valid samples after detection. Strict compare keeps the
    // earliest of equal peaks. A broken run is simply restarted by the next
    // run start.
    // ------------------------------------------------------------------
    localparam int PEAK_WIN = CONFIRM_COUNT * 4;
    localparam int PW       = $clog2(PEAK_WIN + 1);

    logic [DATA_WIDTH-1:0] peak_q;
    logic [TIME_WIDTH-1:0] ptime_q;
    logic [PW-1:0]         post_q;
    logic                  trk_q;
    logic                  pvalid_q;
    logic                  run_start;

    assign run_start = (state_q == BLANK || state_q == ARMED) &&
                       (state_d == CONFIRM || state_d == DETECTED);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            peak_q   <= '0;
            ptime_q  <= '0;
            post_q   <= '0;
            trk_q    <= 1'b0;
            pvalid_q <= 1'b0;
        end else if (bus.burst_start_in) begin
            peak_q   <= '0;
            ptime_q  <= '0;
            post_q   <= '0;
            trk_q    <= 1'b0;
            pvalid_q <= 1'b0;
        end else begin
            pvalid_q <= 1'b0;
            if (run_start) begin
                peak_q  <= mag_q;
                ptime_q <= time_q;
                post_q  <= '0;
                trk_q   <= 1'b1;
            end else if (trk_q && vld_q && (state_q == CONFIRM || state_q == DETECTED)) begin
                if (mag_q > peak_q) begin
                    peak_q  <= mag_q;
                    ptime_q <= time_q;
                end
                if (state_q == DETECTED) begin
                    post_q <= post_q + PW'(1);
                    if (post_q + PW'(1) == PW'(PEAK_WIN)) begin
                        trk_q    <= 1'b0;
                        pvalid_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.peak_out       = peak_q;
    assign bus.peak_time_out  = ptime_q;
    assign bus.peak_valid_out = pvalid_q;
`else
    assign bus.peak_out       = '0;
    assign bus.peak_time_out  = '0;
    assign bus.peak_valid_out = 1'b0;
`endif

endmodule

// File: tb/tb_echo_detector.sv
// tb_echo_detector
//   Directed vectors with hand-computed expectations. Stimulus pushes the
//   expected echo/no-echo events (kind, echo time, cycle) into a queue; a
//   monitor pops and compares whenever the DUT pulses an event. Level outputs
//   are checked directly at quiet points.
module tb_echo_detector;
    localparam int DW = 16;
    localparam int TW = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    echo_detector_if #(.DATA_WIDTH(DW), .TIME_WIDTH(TW)) bus ();

    echo_detector #(
        .DATA_WIDTH   (DW),
        .TIME_WIDTH   (TW),
        .BLANK_CYCLES (1048576),
        .CONFIRM_COUNT(4),
        .HYST         (512)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus   (bus)
    );

    typedef struct {
        bit            is_echo;
        logic [TW-1:0] t;
        int            cyc;
    } ev_t;

    ev_t exp_q[$];
    int  n_chk  = 0;
    int  n_pass = 0;
    int  cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // monitor: every pulse must match the head of the expectation queue
    always @(negedge clk) begin : monitor
        ev_t e;
        if (!rst && (bus.echo_valid_out || bus.no_echo_out)) begin
            chk("pulse_exclusive", 64'(bus.echo_valid_out & bus.no_echo_out), 64'(0));
            if (exp_q.size() == 0) begin
                chk("unexpected_event", 64'(1), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk("event_kind", 64'(bus.echo_valid_out), 64'(e.is_echo));
                chk("event_cycle", 64'(cyc), 64'(e.cyc));
                if (e.is_echo) chk("event_echo_time", 64'(bus.echo_time_out), 64'(e.t));
            end
        end
    end

    task automatic drv(input bit b, input bit v, input logic signed [DW-1:0] s, input logic [TW-1:0] t);
        @(negedge clk);
        bus.burst_start_in  = b;
        bus.sample_valid_in = v;
        bus.sample_in       = s;
        bus.time_in         = t;
    endtask

    task automatic smp(input logic signed [DW-1:0] s, input logic [TW-1:0] t);
        drv(1'b0, 1'b1, s, t);
    endtask

    task automatic nop(input int n);
        repeat (n) drv(1'b0, 1'b0, '0, '0);
    endtask

    task automatic burst();
        drv(1'b1, 1'b0, '0, '0);
    endtask

    // called right after the sample that should trigger the event
    task automatic exp_echo(input logic [TW-1:0] t);
        ev_t e;
        e.is_echo = 1'b1; e.t = t; e.cyc = cyc + 2;
        exp_q.push_back(e);
    endtask

    task automatic exp_noecho();
        ev_t e;
        e.is_echo = 1'b0; e.t = '0; e.cyc = cyc + 2;
        exp_q.push_back(e);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin : stim
        logic signed [DW-1:0] hyst_a [5];
        logic signed [DW-1:0] hyst_b [7];
        hyst_a = '{16'sd6000, -16'sd6000, 16'sd4700, 16'sd6000, 16'sd6000};
        hyst_b = '{16'sd6000, 16'sd6000, 16'sd4000, 16'sd6000, 16'sd6000, 16'sd6000, 16'sd6000};

        bus.burst_start_in  = 1'b0;
        bus.sample_valid_in = 1'b0;
        bus.sample_in       = '0;
        bus.time_in         = '0;
        bus.threshold_in    = 16'd5000;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_detected", 64'(bus.echo_detected_out), 64'(0));
        chk("rst_valid", 64'(bus.echo_valid_out), 64'(0));
        chk("rst_no_echo", 64'(bus.no_echo_out), 64'(0));
        chk("rst_time", 64'(bus.echo_time_out), 64'(0));
        rst = 1'b0;

        // IDLE ignores samples before the first burst
        for (int i = 0; i < 4; i++) smp(16'sd20000, 24'(1100000 + i));
        nop(3);
        chk("idle_ignores", 64'(bus.echo_detected_out), 64'(0));

        // blanking: strong samples inside the blank window are ignored
        burst();
        for (int i = 0; i < 4; i++) smp(16'sd20000, 24'(1000 + i));
        for (int i = 0; i < 4; i++) smp(16'sd6000, 24'(1048576 + i));
        exp_echo(24'd1048576);
        nop(3);
        chk("blank_detected", 64'(bus.echo_detected_out), 64'(1));
        chk("blank_time", 64'(bus.echo_time_out), 64'(1048576));

        // hysteresis hold: 4700 is within the band and holds the count
        burst();
        nop(1);
        chk("burst_clears_det", 64'(bus.echo_detected_out), 64'(0));
        chk("burst_clears_time", 64'(bus.echo_time_out), 64'(0));
        for (int i = 0; i < 5; i++) smp(hyst_a[i], 24'(2000000 + i));
        exp_echo(24'd2000000);
        nop(3);
        chk("hyst_hold_time", 64'(bus.echo_time_out), 64'(2000000));

        // hysteresis abort: 4000 is below the band, run restarts at 3000003
        burst();
        for (int i = 0; i < 7; i++) smp(hyst_b[i], 24'(3000000 + i));
        exp_echo(24'd3000003);
        nop(3);
        chk("hyst_abort_time", 64'(bus.echo_time_out), 64'(3000003));

        // saturation, with invalid gaps inside the run
        bus.threshold_in = 16'd32000;
        burst();
        smp(-16'sd32768, 24'd4000000);
        nop(2);
        smp(-16'sd32768, 24'd4000001);
        nop(1);
        smp(-16'sd32768, 24'd4000002);
        smp(-16'sd32768, 24'd4000003);
        exp_echo(24'd4000000);
        nop(3);
        chk("sat_detected", 64'(bus.echo_detected_out), 64'(1));

        // strict compare: 5000 is not above 5000, -5001 is
        bus.threshold_in = 16'd5000;
        burst();
        smp(16'sd5000, 24'd5000000);
        for (int i = 1; i <= 4; i++) smp(-16'sd5001, 24'(5000000 + i));
        exp_echo(24'd5000001);
        nop(3);
        chk("sign_time", 64'(bus.echo_time_out), 64'(5000001));

        // timeout at the last time value, then DONE ignores samples
        burst();
        smp(16'sd0, 24'd16777213);
        smp(16'sd0, 24'd16777214);
        smp(16'sd0, 24'd16777215);
        exp_noecho();
        nop(3);
        chk("timeout_no_det", 64'(bus.echo_detected_out), 64'(0));
        for (int i = 0; i < 4; i++) smp(16'sd20000, 24'd16777215);
        nop(3);
        chk("done_ignores", 64'(bus.echo_detected_out), 64'(0));

        // burst coincident with a valid sample: burst wins, sample discarded
        burst();
        for (int i = 0; i < 4; i++) smp(16'sd6000, 24'(6000000 + i));
        exp_echo(24'd6000000);
        nop(3);
        chk("simul_pre_det", 64'(bus.echo_detected_out), 64'(1));
        drv(1'b1, 1'b1, 16'sd9000, 24'd6000010);
        nop(1);
        chk("simul_det_drop", 64'(bus.echo_detected_out), 64'(0));
        for (int i = 11; i <= 13; i++) smp(16'sd9000, 24'(6000000 + i));
        nop(3);
        chk("simul_sample_discarded", 64'(bus.echo_detected_out), 64'(0));
        smp(16'sd9000, 24'd6000014);
        exp_echo(24'd6000011);
        nop(3);

        // asynchronous reset in the middle of a confirmation run
        burst();
        smp(16'sd6000, 24'd7000000);
        smp(16'sd6000, 24'd7000001);
        nop(2);
        chk("pre_reset_time", 64'(bus.echo_time_out), 64'(7000000));
        #2 rst = 1'b1;
        #1;
        chk("async_rst_time", 64'(bus.echo_time_out), 64'(0));
        chk("async_rst_det", 64'(bus.echo_detected_out), 64'(0));
        chk("async_rst_valid", 64'(bus.echo_valid_out | bus.no_echo_out), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int i = 2; i <= 5; i++) smp(16'sd6000, 24'(7000000 + i));
        nop(3);
        chk("post_reset_idle", 64'(bus.echo_detected_out), 64'(0));
        burst();
        for (int i = 0; i < 4; i++) smp(16'sd7000, 24'(7100000 + i));
        exp_echo(24'd7100000);
        nop(3);
        chk("post_reset_recover", 64'(bus.echo_detected_out), 64'(1));

`ifndef ECHO_PEAK_TRACK_EN
        chk("peak_tied", 64'(bus.peak_out), 64'(0));
        chk("peak_valid_tied", 64'(bus.peak_valid_out), 64'(0));
`endif

        nop(4);
        chk("all_events_seen", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/echo_detector.md
Name: echo_detector

Overview:
- Downstream stage of the receive beamformer: consumes the aggregated waveform samples and decides per ping whether an echo arrived and when.
- Provides a registered, debounced echo flag and the captured time-since-emission of the echo onset.
- These outputs feed time_of_flight (range) and the velocity stage.
- Replaces the single-compare latch in the top level with blanking, confirmation and timeout.

Parameters:
- DATA_WIDTH, 16, width of signed sample_in and unsigned threshold_in.
- TIME_WIDTH, 24, width of time_in / echo_time_out (clock cycles since burst start).
- BLANK_CYCLES, 1048576, time_in values below this are ignored (transmit ring-down).
- CONFIRM_COUNT, 4, consecutive above-threshold valid samples required to declare echo (>=1).
- HYST, 512, hysteresis below threshold that aborts a confirmation.

Ports:
- clk_in  input  1  system clock (100 MHz).
- rst_in  input  1  reset; asynchronous, active-high.
- burst_start_in  input  1  one-cycle pulse; new ping, synchronously restarts detection.
- sample_in  input  DATA_WIDTH  signed aggregated waveform sample.
- sample_valid_in  input  1  sample_in/time_in qualifier.
- time_in  input  TIME_WIDTH  time since emission, sampled with sample_in.
- threshold_in  input  DATA_WIDTH  unsigned detection threshold; quasi-static.
- echo_detected_out  output  1  level; high from detection until next burst_start_in.
- echo_valid_out  output  1  one-cycle pulse on detection.
- echo_time_out  output  TIME_WIDTH  time_in of first sample of the confirmed run.
- no_echo_out  output  1  one-cycle pulse on timeout without echo.

Behaviour:
- Reset (async):
  - State IDLE.
  - All outputs 0.
  - Pipeline valid 0; confirm counter 0.
- Stage 1 (registered):
  - mag = |sample_in|; -2^(DATA_WIDTH-1) saturates to 2^(DATA_WIDTH-1)-1.
  - time_in and valid are registered alongside mag.
- Stage 2: FSM acts on stage-1 registers.
  - Detection pulse appears 2 cycles after the sample_valid_in of the confirming sample.
- low_thr = threshold_in - HYST, clamped at 0; "above" means mag > threshold_in (strict).
- IDLE:
  - Ignore samples.
  - burst_start_in -> BLANK.
- BLANK:
  - On a valid sample with time >= BLANK_CYCLES: evaluate it as ARMED would (same cycle).
  - Otherwise stay.
- ARMED:
  - Valid and above -> capture time into echo_time_out, counter=1.
  - If CONFIRM_COUNT==1 -> DETECTED, else -> CONFIRM.
- CONFIRM (valid samples only):
  - above: counter+1; counter reaching CONFIRM_COUNT -> DETECTED.
  - low_thr <= mag <= threshold_in: hold counter, stay.
  - mag < low_thr: counter=0 -> ARMED; echo_time_out keeps its stale value (not qualified).
- DETECTED:
  - Entry: echo_valid_out=1 for one cycle; echo_detected_out=1.
  - Hold until burst_start_in.
- Timeout: in BLANK/ARMED/CONFIRM, a valid sample with time == 2^TIME_WIDTH-1 and not causing detection -> no_echo_out one cycle -> DONE.
- DONE: wait for burst_start_in.
- burst_start_in from any non-IDLE state:
  - -> BLANK.
  - Clear echo_detected_out, echo_time_out, counter, stage-1 valid.
  - A sample_valid_in in the same cycle is discarded (burst wins).
- Invalid cycles (sample_valid_in=0) never change the counter or state, except on burst_start_in.
- echo_valid_out and no_echo_out are never high together and fire at most once per ping.

Optional Feature:
- Macro ECHO_PEAK_TRACK_EN.
- When defined:
  - Extra outputs peak_out (DATA_WIDTH), peak_time_out (TIME_WIDTH), peak_valid_out (1).
  - From the first above sample until CONFIRM_COUNT*4 valid samples after DETECTED entry, track max mag; ties keep the earliest.
  - Then pulse peak_valid_out one cycle.
  - Cleared by burst_start_in/reset.
- When undefined: these ports still exist, tied to 0; no tracking logic.

Test Plan:
- Reset mid-CONFIRM: assert rst_in asynchronously -> all outputs 0 in the same cycle; after release, samples ignored until burst_start_in.
- Blanking: threshold 5000, samples 20000 at time 1000 (< BLANK_CYCLES) -> no detection; then samples 6000 at times 1048576..1048579 -> echo_valid_out pulse 2 cycles after 4th sample, echo_time_out=1048576.
- Hysteresis: threshold 5000, mags 6000, 6000, 4700, 6000, 6000 -> detect with echo_time_out = first sample's time; with 4000 in place of 4700 -> abort, restart counting at the next above sample.
- Saturation/sign: sample -32768 x4 post-blank, threshold 32000 -> detect; sample -5001 counts as above for threshold 5000.
- Timeout: all samples 0, time reaches 16777215 -> no_echo_out single pulse, echo_detected_out stays 0.
- Simultaneous: burst_start_in in DETECTED coincident with valid sample 9000 -> echo_detected_out drops next cycle, that sample never counted.
